hdmi_lock_monitor: RTL

Supervises the PLL lock output of the HDMI clock generator and turns it into a clean, synchronous video-domain reset. Runs on the 27 MHz crystal clock, so it keeps running when the PLL output stops. It synchronises the asynchronous `lock`, requires lock to stay stable for a settle window before releasing `video_reset`, and detects and counts lock losses. An optional start-up timeout requests a PLL reset.

---
 rtl/hdmi_lock_monitor.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_lock_monitor.sv
// hdmi_lock_monitor
//
// Watches the HDMI PLL lock output and turns it into a clean, synchronous
// video-domain reset. Runs on the 27 MHz crystal clock, so it keeps working
// when the PLL output clock stops. The raw lock is synchronised first. It
// must then stay high for a settle window before video_reset is released.
// Lock losses while running are flagged and counted.
//
// Optional feature (macro HDMI_LOCK_MONITOR_TIMEOUT_EN): a start-up timeout
// that forces a hold period with pll_reset asserted if RUN is not reached
// in time.
//
// Ports:
//   clk          27 MHz crystal clock
//   reset        synchronous, active-high reset
//   lock         raw PLL lock, asynchronous to clk
//   video_reset  active-high reset for the video-domain consumers
//   ready        high only while locked and settled (RUN)
//   lost         one-cycle pulse on each RUN -> LOST transition
//   lost_count   saturating count of lock losses
//   pll_reset    PLL reset request (constant 0 without the macro)
//   timeout      sticky start-up timeout flag (constant 0 without the macro)

module hdmi_lock_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 27000,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    output logic       video_reset,
    output logic       ready,
    output logic       lost,
    output logic [7:0] lost_count,
    output logic       pll_reset,
    output logic       timeout
);

    // One counter is shared by the settle window and the loss hold period.
    localparam int CNT_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        LOST   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic                 lost_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 lock_s;

`ifdef HDMI_LOCK_MONITOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_next;
    logic          timeout_q;
    logic          timeout_next;
    // Marks that the current LOST period was entered through a timeout.
    logic          to_hold;
    logic          to_hold_next;
`endif

    // Synchroniser chain; only its last stage is used by the rest of the logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State, shared counter and loss bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT;
            cnt        <= '0;
            lost       <= 1'b0;
            lost_count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lost  <= lost_next;
            if (lost_next && (lost_count != 8'hFF)) begin
                lost_count <= lost_count + 8'd1;
            end
        end
    end

    // Next-state logic. lost is registered so that its pulse lines up with
    // the first cycle of LOST, where video_reset also rises.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lost_next  = 1'b0;

        case (state)
            WAIT: begin
                cnt_next = '0;
                if (lock_s) begin
                    state_next = SETTLE;
                    cnt_next   = CW'(1);
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else if (cnt == CW'(SETTLE_CYCLES)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!lock_s) begin
                    state_next = LOST;
                    lost_next  = 1'b1;
                end
            end
            LOST: begin
                // Leaves after exactly HOLD_CYCLES cycles regardless of lock_s.
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
        endcase

`ifdef HDMI_LOCK_MONITOR_TIMEOUT_EN
        tcnt_next    = tcnt;
        timeout_next = timeout_q;
        to_hold_next = to_hold;

        // The timeout overrides any other WAIT/SETTLE decision, including a
        // settle window completing on the same cycle.
        if ((state == WAIT) || (state == SETTLE)) begin
            if (tcnt == TW'(TIMEOUT_CYCLES)) begin
                state_next   = LOST;
                cnt_next     = '0;
                tcnt_next    = '0;
                timeout_next = 1'b1;
                to_hold_next = 1'b1;
            end else if (state_next == RUN) begin
                tcnt_next = '0;
            end else begin
                tcnt_next = tcnt + TW'(1);
            end
        end

        if ((state == LOST) && (state_next == WAIT)) begin
            to_hold_next = 1'b0;
        end
`endif
    end

`ifdef HDMI_LOCK_MONITOR_TIMEOUT_EN
    // Timeout counter, sticky flag and the timeout-hold marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt      <= '0;
            timeout_q <= 1'b0;
            to_hold   <= 1'b0;
        end else begin
            tcnt      <= tcnt_next;
            timeout_q <= timeout_next;
            to_hold   <= to_hold_next;
        end
    end

    assign pll_reset = (state == LOST) && to_hold;
    assign timeout   = timeout_q;
`else
    // Timeout supervision is compiled out. TIMEOUT_CYCLES is never negative,
    // so this is constant 0; referencing it keeps one parameter list for both builds.
    assign pll_reset = 1'b0;
    assign timeout   = (TIMEOUT_CYCLES < 0);
`endif

    // Outputs decode straight from the state register.
    assign video_reset = (state != RUN);
    assign ready       = (state == RUN);

endmodule
